// File: rtl/map_rom_arbiter.sv
// map_rom_arbiter: single-port access arbiter for the 32Kx8 MAP tile ROM.
// Shares one synchronous memory port between the ROM loader and the MAP video fetch path.
// Optional feature macro: MAP_ARB_BLANK_ON_LOAD_EN. When it is defined, video fetches are
// blanked while the loader has ld_cs asserted.
//
// Handshake semantics:
//   vid_req is a fire-and-forget pulse. It is always taken, and the most recent address wins.
//   vid_ack pulses for one cycle, and vid_data is valid from that cycle until the next ack.
//   The loader presents valid = ld_wr & ld_cs. ld_wait acts as an inverted ready signal.
//   A write is transferred when valid=1 and ld_wait=0. A write presented while ld_wait=1 is dropped.
//
// dbg_state exposes the FSM state: 0=IDLE, 1=VREAD, 2=LWRITE.
module map_rom_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  RESETn,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [DATA_WIDTH-1:0] vid_data,
    output logic                  vid_ack,
    input  logic                  ld_wr,
    input  logic                  ld_cs,
    input  logic [19:0]           ld_addr,
    input  logic [7:0]            ld_data,
    output logic                  ld_wait,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_cs,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VREAD  = 2'd1,
        LWRITE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [1:0]            lat_cnt;
    logic                  vid_pend;
    logic [ADDR_WIDTH-1:0] vid_pend_addr;
    logic                  ld_full;
    logic [ADDR_WIDTH-1:0] ld_buf_addr;
    logic [DATA_WIDTH-1:0] ld_buf_data;
    logic [3:0]            starve_cnt;
    logic                  blank_rd;

    logic                  ld_accept;
    logic                  v_any;
    logic                  l_any;
    logic [ADDR_WIDTH-1:0] v_gaddr;
    logic [ADDR_WIDTH-1:0] l_gaddr;
    logic [DATA_WIDTH-1:0] l_gdata;
    logic                  starved;
    logic                  blank;
    logic                  grant_v;
    logic                  grant_l;
    logic                  read_done;
    logic                  unused_ld_bits;

    // Only the low ADDR_WIDTH bits of the loader address select a ROM byte.
    assign unused_ld_bits = &{1'b0, ld_addr[19:ADDR_WIDTH]};

`ifdef MAP_ARB_BLANK_ON_LOAD_EN
    // During a download the loader owns the port, and video reads return blank data.
    assign blank = ld_cs;
`else
    assign blank = 1'b0;
`endif

    // An incoming request or write can be granted in the same IDLE cycle it arrives.
    // If something is already pending, the pending item is served first.
    assign ld_accept = ld_wr & ld_cs & ~ld_full;
    assign v_any     = vid_pend | vid_req;
    assign v_gaddr   = vid_pend ? vid_pend_addr : vid_addr;
    assign l_any     = ld_full | ld_accept;
    assign l_gaddr   = ld_full ? ld_buf_addr : ld_addr[ADDR_WIDTH-1:0];
    assign l_gdata   = ld_full ? ld_buf_data : DATA_WIDTH'(ld_data);
    assign starved   = (starve_cnt == 4'(STARVE_MAX));
    assign read_done = (state == VREAD) && (lat_cnt == 2'(RD_LAT));
    assign ld_wait   = ld_full;
    assign dbg_state = state;

    // Arbitration and next-state decision.
    always_comb begin
        state_nxt = state;
        grant_v   = 1'b0;
        grant_l   = 1'b0;
        case (state)
            IDLE: begin
                if (l_any && (!v_any || starved || blank)) begin
                    grant_l   = 1'b1;
                    state_nxt = LWRITE;
                end else if (v_any) begin
                    grant_v   = 1'b1;
                    state_nxt = VREAD;
                end
            end
            VREAD: begin
                if (read_done) state_nxt = IDLE;
            end
            LWRITE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register and read-latency counter.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state   <= IDLE;
            lat_cnt <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == VREAD && !read_done) lat_cnt <= lat_cnt + 2'd1;
            else                              lat_cnt <= 2'd0;
        end
    end

    // Video pending latch. The newest address wins, and a same-cycle request outlives a grant.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            vid_pend      <= 1'b0;
            vid_pend_addr <= '0;
        end else begin
            if (grant_v)      vid_pend <= vid_pend & vid_req;
            else if (vid_req) vid_pend <= 1'b1;
            if (vid_req) vid_pend_addr <= vid_addr;
        end
    end

    // One-entry loader buffer. It stays full through the write cycle itself.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            ld_full     <= 1'b0;
            ld_buf_addr <= '0;
            ld_buf_data <= '0;
        end else begin
            if (ld_accept) begin
                ld_full     <= 1'b1;
                ld_buf_addr <= ld_addr[ADDR_WIDTH-1:0];
                ld_buf_data <= DATA_WIDTH'(ld_data);
            end else if (state == LWRITE) begin
                ld_full <= 1'b0;
            end
        end
    end

    // Starve counter: counts video grants taken while a loader write is waiting.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            starve_cnt <= 4'd0;
        end else begin
            if (grant_l || blank)     starve_cnt <= 4'd0;
            else if (grant_v && l_any) starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Registered memory port. Address and data hold their values while the port is idle.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            blank_rd <= 1'b0;
        end else begin
            mem_cs <= grant_l | (grant_v & ~blank);
            mem_we <= grant_l;
            if (grant_l) begin
                mem_addr <= l_gaddr;
                mem_din  <= l_gdata;
            end else if (grant_v && !blank) begin
                mem_addr <= v_gaddr;
            end
            if (grant_v) blank_rd <= blank;
        end
    end

    // Video return path: capture the read byte and pulse the acknowledge.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            vid_ack  <= 1'b0;
            vid_data <= '0;
        end else begin
            vid_ack <= read_done;
            if (read_done) vid_data <= blank_rd ? '0 : mem_dout;
        end
    end

endmodule
